matrix_responder: RTL
=====================

MATRIX_RESPONDER -- requirements
Module: matrix_responder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  command/data qualifier.
REQ-005 in_data  input  31  matrix element, unsigned; ignored when unused.
REQ-006 size  input  2  side N = 2^(size+1), giving 2/4/8/16; sampled only on first in_valid cycle of action 0.
REQ-007 action  input  3  command, sampled only on first in_valid cycle.
REQ-008 out_valid  output  1  high while a result element is presented.
REQ-009 out_data  output  31  result element, row-major; 0 whenever out_valid=0.

Function
REQ-010 SHALL hold two banks of 256x31 element registers, a bank-select bit, and a stored size; active bank = bank-select.
REQ-011 Actions: 0 LOAD, 1 ADD, 2 SUB, 3 TRANSPOSE, 4 HMIRROR, 5 VFLIP, 6 ROT90CW, 7 SHOW.
REQ-012 Actions 0-2 SHALL take in_valid high for exactly N*N consecutive cycles, element k (row-major) on cycle k; actions 3-7 take in_valid high for exactly one cycle.
REQ-013 LOAD SHALL latch size into stored size on its first cycle and write element k to active bank[k].
REQ-014 ADD/SUB SHALL use stored size and write active[k] = active[k] +/- in_data mod 2^31.
REQ-015 Every action SHALL be followed by N*N output cycles, out_valid held high continuously, element k on output cycle k.
REQ-016 Actions 0-2 and 7 SHALL output active bank in row-major order, unchanged by output.
REQ-017 Actions 3-6 SHALL output, for k=(r,c), active[src(r,c)]: TRANSPOSE (c,r); HMIRROR (r,N-1-c); VFLIP (N-1-r,c); ROT90CW (N-1-c,r); source index = row*N+col.
REQ-018 Actions 3-6 SHALL write each output element to the other bank at index k and toggle bank-select on the edge ending the last output cycle, so the result becomes the stored matrix.
REQ-019 Latency: out_valid SHALL rise on the 2nd rising edge after the edge that sampled the last in_valid=1 cycle (one idle cycle between).
REQ-020 out_valid and out_data SHALL be registered outputs.
REQ-021 FSM states: IDLE -> IN (actions 0-2, counting N*N elements) -> GAP (1 cycle) -> OUT (N*N cycles) -> IDLE; actions 3-7 go IDLE -> GAP directly.
REQ-022 in_valid asserted while in GAP or OUT SHALL be ignored; a new command SHALL be accepted in IDLE only.
REQ-023 Element counter SHALL be 8 bits and compare against N*N-1; no wrap beyond it.
REQ-024 ADD/SUB/3-7 before any LOAD SHALL operate on the reset matrix (zeros, N=2).

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, out_valid=0, out_data=0, stored size=0, bank-select=0, and clear both banks to 0, including during IN, GAP or OUT.
REQ-026 After rst deasserts, the first in_valid SHALL be accepted on the next edge.

Verification
REQ-027 rst high 2 cycles -> out_valid=0, out_data=0; then action 7 -> outputs 0,0,0,0.
REQ-028 LOAD size=0, data 1,2,3,4 -> idle gap 1 cycle, then out 1,2,3,4 on 4 consecutive cycles, then out_valid=0, out_data=0.
REQ-029 Then ADD 10,20,30,40 -> 11,22,33,44; then SUB 12,0,0,0 -> 2147483647,22,33,44.
REQ-030 LOAD size=0 1,2,3,4; TRANSPOSE -> 1,3,2,4; SHOW -> 1,3,2,4.
REQ-031 LOAD size=1 data 0..15; ROT90CW -> first row 12,8,4,0 and last row 15,11,7,3; HMIRROR then -> first row 0,4,8,12.
REQ-032 LOAD size=3 (256 elements); assert rst at output cycle 100 -> out_valid=0 next edge; SHOW -> four zeros.

Source files
------------

// File: rtl/matrix_responder_if.sv
// rtl/matrix_responder_if.sv - command input and result output bundle for matrix_responder
interface matrix_responder_if;
  logic        in_valid;
  logic [30:0] in_data;
  logic [1:0]  size;
  logic [2:0]  action;
  logic        out_valid;
  logic [30:0] out_data;

  modport master (output in_valid, in_data, size, action, input out_valid, out_data);
  modport slave  (input in_valid, in_data, size, action, output out_valid, out_data);
endinterface

// File: rtl/matrix_responder.sv
// rtl/matrix_responder.sv - double-banked NxN matrix store with load/add/sub and
// geometric transforms that stream the result row-major and commit it to the spare bank
module matrix_responder (
  input  logic              clk,
  input  logic              rst,
  matrix_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IN, GAP, OUT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  act_q, act_d;
  logic [1:0]  size_q, size_d;
  logic        bank_sel_q, bank_sel_d;
  logic        out_valid_q, out_valid_d;
  logic [30:0] out_data_q, out_data_d;
  logic [30:0] bank_q [2][256];

  logic        wr_en, wr_bank;
  logic [7:0]  wr_idx;
  logic [30:0] wr_data;
  logic [1:0]  eff_size;
  logic [7:0]  last, idx, src;
  logic [3:0]  nm1, r, c, sr, sc;
  logic [30:0] cur;
  logic        is_xform;

  function automatic logic [30:0] apply_op(input logic [2:0] op, input logic [30:0] a,
                                           input logic [30:0] b);
    case (op)
      3'd1:    apply_op = a + b;
      3'd2:    apply_op = a - b;
      default: apply_op = b;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    size_d      = size_q;
    bank_sel_d  = bank_sel_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    wr_en       = 1'b0;
    wr_bank     = bank_sel_q;
    wr_idx      = cnt_q;
    wr_data     = '0;

    // A LOAD uses the size it carries from its very first element onward
    eff_size = (state_q == IDLE && bus.action == 3'd0) ? bus.size : size_q;
    last     = 8'((9'd4 << {eff_size, 1'b0}) - 9'd1);
    nm1      = 4'((5'd2 << size_q) - 5'd1);
    c        = cnt_q[3:0] & nm1;
    r        = 4'(cnt_q >> ({1'b0, size_q} + 3'd1));
    is_xform = (act_q >= 3'd3) && (act_q <= 3'd6);
    case (act_q)
      3'd3:    begin sr = c;       sc = r;       end
      3'd4:    begin sr = r;       sc = nm1 - c; end
      3'd5:    begin sr = nm1 - r; sc = c;       end
      3'd6:    begin sr = nm1 - c; sc = r;       end
      default: begin sr = r;       sc = c;       end
    endcase
    src = 8'({4'b0, sr} << ({1'b0, size_q} + 3'd1)) | {4'b0, sc};
    idx = (state_q == OUT && is_xform) ? src : cnt_q;
    cur = bank_q[bank_sel_q][idx];

    case (state_q)
      IDLE: begin
        // out_valid_q still high means the final element is on the bus
        if (bus.in_valid && !out_valid_q) begin
          act_d = bus.action;
          cnt_d = '0;
          if (bus.action <= 3'd2) begin
            if (bus.action == 3'd0) size_d = bus.size;
            wr_en   = 1'b1;
            wr_data = apply_op(bus.action, cur, bus.in_data);
            cnt_d   = 8'd1;
            state_d = IN;
          end else begin
            state_d = GAP;
          end
        end
      end
      IN: begin
        if (bus.in_valid) begin
          wr_en   = 1'b1;
          wr_data = apply_op(act_q, cur, bus.in_data);
          if (cnt_q == last) begin
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      GAP: begin
        cnt_d   = '0;
        state_d = OUT;
      end
      OUT: begin
        out_valid_d = 1'b1;
        out_data_d  = cur;
        if (is_xform) begin
          wr_en   = 1'b1;
          wr_bank = ~bank_sel_q;
          wr_data = cur;
        end
        if (cnt_q == last) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (is_xform) bank_sel_d = ~bank_sel_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      act_q       <= '0;
      size_q      <= '0;
      bank_sel_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 256; i++)
          bank_q[b][i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      size_q      <= size_d;
      bank_sel_q  <= bank_sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (wr_en) bank_q[wr_bank][wr_idx] <= wr_data;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule
